// File: rtl/compare_4_32_seq_if.sv
// Handshake and operand/result bundle for compare_4_32_seq.
// The master drives start, the operands and out_ack; the slave (the comparator) drives everything else.
interface compare_4_32_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             busy;
   logic             out_valid;
   logic             out_ack;
   logic [3:0]       lrg_mask;
   logic [3:0]       sml_mask;
   logic [WIDTH-1:0] lrg_val;
   logic [WIDTH-1:0] sml_val;

   modport master (
      output start, a, b, c, d, out_ack,
      input  busy, out_valid, lrg_mask, sml_mask, lrg_val, sml_val
   );

   modport slave (
      input  start, a, b, c, d, out_ack,
      output busy, out_valid, lrg_mask, sml_mask, lrg_val, sml_val
   );
endinterface

// File: rtl/compare_4_32_seq.sv
// Sequenced 4-operand max/min finder sharing one comparator pair; marks every operand tied with max/min.
// Define SIGNED_CMP_EN for two's-complement comparison; unsigned comparison otherwise.
module compare_4_32_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   compare_4_32_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      MARK = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       idx_q;
   logic [WIDTH-1:0] op_q [4];
   logic [WIDTH-1:0] lrg_q;
   logic [WIDTH-1:0] sml_q;
   logic [3:0]       lrg_mask_q;
   logic [3:0]       sml_mask_q;
   logic             busy_q;
   logic             valid_q;
   logic             busy_d;
   logic             valid_d;

   // Shared comparator: the operand selected by idx against the running max and min.
   logic [WIDTH-1:0] op_sel;
   logic             op_gt_lrg;
   logic             op_lt_sml;
   logic             op_eq_lrg;
   logic             op_eq_sml;

   assign op_sel = op_q[idx_q];

`ifdef SIGNED_CMP_EN
   assign op_gt_lrg = $signed(op_sel) > $signed(lrg_q);
   assign op_lt_sml = $signed(op_sel) < $signed(sml_q);
`else
   assign op_gt_lrg = op_sel > lrg_q;
   assign op_lt_sml = op_sel < sml_q;
`endif
   assign op_eq_lrg = (op_sel == lrg_q);
   assign op_eq_sml = (op_sel == sml_q);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start)      state_d = SCAN;
         SCAN:    if (idx_q == 2'd3)  state_d = MARK;
         MARK:    if (idx_q == 2'd3)  state_d = DONE;
         DONE:    if (bus.out_ack)    state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Status flags are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      busy_d  = (state_d != IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: the operand file is reset explicitly because a reset mid-operation must leave no stale operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) op_q[i] <= '0;
         idx_q      <= 2'd0;
         lrg_q      <= '0;
         sml_q      <= '0;
         lrg_mask_q <= 4'b0000;
         sml_mask_q <= 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_q[0]    <= bus.a;
                  op_q[1]    <= bus.b;
                  op_q[2]    <= bus.c;
                  op_q[3]    <= bus.d;
                  lrg_q      <= bus.a;
                  sml_q      <= bus.a;
                  lrg_mask_q <= 4'b0000;
                  sml_mask_q <= 4'b0000;
                  idx_q      <= 2'd1;
               end
            end
            SCAN: begin
               if (op_gt_lrg) lrg_q <= op_sel;
               if (op_lt_sml) sml_q <= op_sel;
               idx_q <= idx_q + 2'd1;  // wraps 3 -> 0 to start the mark pass at operand A
            end
            MARK: begin
               if (op_eq_lrg) lrg_mask_q[2'd3 - idx_q] <= 1'b1;
               if (op_eq_sml) sml_mask_q[2'd3 - idx_q] <= 1'b1;
               idx_q <= idx_q + 2'd1;
            end
            default: ;  // DONE holds the result until the next accepted start
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = valid_q;
   assign bus.lrg_mask  = lrg_mask_q;
   assign bus.sml_mask  = sml_mask_q;
   assign bus.lrg_val   = lrg_q;
   assign bus.sml_val   = sml_q;

endmodule
